// File: rtl/rr_mux_sel_sequencer.sv
// rtl/rr_mux_sel_sequencer.sv - round-robin select sequencer driving an 8:1 mux sel input
//
// Purpose:
//   Grants eight request lines in round-robin order and holds each winner's
//   select code for DWELL cycles. A valid strobe marks cycles where the
//   downstream mux output is meaningful.
//
// Ports:
//   i_clk        - system clock, rising edge
//   i_rst        - synchronous active-high reset
//   i_en         - scan enable, sampled only at grant decision points
//   i_req[7:0]   - per-channel request, bit i selects mux input i
//   o_sel[2:0]   - binary select code of the granted channel
//   o_grant[7:0] - one-hot image of o_sel while valid, zero otherwise
//   o_valid      - high while a grant is being held
//   o_last_slot  - high on the final cycle of each dwell period
//   o_grant_cnt  - grants issued since reset, wraps 255->0

module rr_mux_sel_sequencer #(
  parameter int DWELL = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [7:0] i_req,
  output logic [2:0] o_sel,
  output logic [7:0] o_grant,
  output logic       o_valid,
  output logic       o_last_slot,
  output logic [7:0] o_grant_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Counter reload: the grant edge itself is the first dwell cycle.
  localparam logic [7:0] LP_RELOAD = 8'(DWELL - 1);

  state_t     r_state;
  logic [2:0] r_ptr;
  logic [2:0] r_sel;
  logic [7:0] r_grant;
  logic       r_valid;
  logic [7:0] r_cnt;
  logic [7:0] r_grant_cnt;

  logic [2:0] w_winner;
  logic       w_start;
  logic       w_busy;

  // Search ptr+1 .. ptr+8. Walking from the farthest offset down to the
  // nearest lets the nearest requester overwrite earlier hits. Offset 8
  // wraps to ptr itself, so a lone requester can be granted again.
  always_comb begin
    logic [2:0] w_idx;
    w_winner = 3'd0;
    for (int i = 8; i >= 1; i--) begin
      w_idx = r_ptr + 3'(i);
      if (i_req[w_idx]) begin
        w_winner = w_idx;
      end
    end
  end

  assign w_start = i_en & (|i_req);

  // Mid-dwell: req/en are ignored until the counter reaches zero.
  assign w_busy = (r_state == ST_HOLD) && (r_cnt != 8'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= 3'd7;
      r_sel       <= 3'd0;
      r_grant     <= 8'd0;
      r_valid     <= 1'b0;
      r_cnt       <= 8'd0;
      r_grant_cnt <= 8'd0;
    end else if (w_busy) begin
      r_cnt <= r_cnt - 8'd1;
    end else if (w_start) begin
      // Decision point with a live request: new grant, no bubble.
      r_state     <= ST_HOLD;
      r_ptr       <= w_winner;
      r_sel       <= w_winner;
      r_grant     <= 8'd1 << w_winner;
      r_valid     <= 1'b1;
      r_cnt       <= LP_RELOAD;
      r_grant_cnt <= r_grant_cnt + 8'd1;
    end else begin
      // Nothing to grant: drop valid, keep sel at its last value.
      r_state <= ST_IDLE;
      r_grant <= 8'd0;
      r_valid <= 1'b0;
      r_cnt   <= 8'd0;
    end
  end

  assign o_sel       = r_sel;
  assign o_grant     = r_grant;
  assign o_valid     = r_valid;
  assign o_grant_cnt = r_grant_cnt;
  assign o_last_slot = r_valid && (r_cnt == 8'd0);

endmodule

// File: tb/tb_rr_mux_sel_sequencer.sv
// tb/tb_rr_mux_sel_sequencer.sv - self-checking bench for rr_mux_sel_sequencer

module tb_rr_mux_sel_sequencer;

  localparam int D0 = 4;
  localparam int D1 = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;

  logic [2:0] sel0, sel1;
  logic [7:0] gnt0, gnt1;
  logic       val0, val1;
  logic       lst0, lst1;
  logic [7:0] cnt0, cnt1;

  always #5 clk = ~clk;

  rr_mux_sel_sequencer #(.DWELL(D0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_req(req),
    .o_sel(sel0), .o_grant(gnt0), .o_valid(val0),
    .o_last_slot(lst0), .o_grant_cnt(cnt0)
  );

  rr_mux_sel_sequencer #(.DWELL(D1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_req(req),
    .o_sel(sel1), .o_grant(gnt1), .o_valid(val1),
    .o_last_slot(lst1), .o_grant_cnt(cnt1)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: per instance, "left" is the number of cycles of the
  // current dwell still to be shown, counting the present one.
  int m_valid[2];
  int m_sel[2];
  int m_ptr[2];
  int m_left[2];
  int m_cnt[2];
  int dw[2];

  int starts[$];   // sel of each new grant seen on instance 0
  int prev_cnt0;
  int pulses;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int arb(input int ptr, input logic [7:0] r);
    for (int k = 1; k <= 8; k++) begin
      if (r[(ptr + k) % 8]) return (ptr + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_edge(input int i, input logic r_rst, input logic r_en, input logic [7:0] r_req);
    int w;
    if (r_rst) begin
      m_valid[i] = 0; m_sel[i] = 0; m_ptr[i] = 7; m_left[i] = 0; m_cnt[i] = 0;
    end else if (m_valid[i] == 0 || m_left[i] == 1) begin
      if (r_en && r_req != 8'd0) begin
        w = arb(m_ptr[i], r_req);
        m_sel[i] = w; m_ptr[i] = w; m_valid[i] = 1;
        m_left[i] = dw[i];
        m_cnt[i] = (m_cnt[i] + 1) % 256;
      end else begin
        m_valid[i] = 0;
        m_left[i] = 0;
      end
    end else begin
      m_left[i] = m_left[i] - 1;
    end
  endtask

  // One clock: drive inputs, step the model at the edge, compare #1 later.
  task automatic cycle(input logic r_rst, input logic r_en, input logic [7:0] r_req);
    rst = r_rst; en = r_en; req = r_req;
    @(posedge clk);
    model_edge(0, r_rst, r_en, r_req);
    model_edge(1, r_rst, r_en, r_req);
    #1;
    chk("sel0",   int'(sel0), m_sel[0]);
    chk("valid0", int'(val0), m_valid[0]);
    chk("grant0", int'(gnt0), m_valid[0] ? (1 << m_sel[0]) : 0);
    chk("last0",  int'(lst0), (m_valid[0] != 0 && m_left[0] == 1) ? 1 : 0);
    chk("cnt0",   int'(cnt0), m_cnt[0]);
    chk("sel1",   int'(sel1), m_sel[1]);
    chk("valid1", int'(val1), m_valid[1]);
    chk("grant1", int'(gnt1), m_valid[1] ? (1 << m_sel[1]) : 0);
    chk("last1",  int'(lst1), (m_valid[1] != 0 && m_left[1] == 1) ? 1 : 0);
    chk("cnt1",   int'(cnt1), m_cnt[1]);
    if (int'(cnt0) != prev_cnt0 && val0) starts.push_back(int'(sel0));
    prev_cnt0 = int'(cnt0);
    if (lst0) pulses++;
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b1, 8'hFF);
    starts.delete();
    pulses = 0;
  endtask

  initial begin
    dw[0] = D0; dw[1] = D1;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 0; m_sel[i] = 0; m_ptr[i] = 7; m_left[i] = 0; m_cnt[i] = 0;
    end
    prev_cnt0 = 0;
    pulses = 0;
    rst = 1'b1; en = 1'b1; req = 8'hFF;

    // Reset held two cycles with all requests up
    cycle(1'b1, 1'b1, 8'hFF);
    cycle(1'b1, 1'b1, 8'hFF);
    chk("rst_sel", int'(sel0), 0);
    chk("rst_valid", int'(val0), 0);
    chk("rst_grant", int'(gnt0), 0);
    chk("rst_cnt", int'(cnt0), 0);
    starts.delete();
    pulses = 0;

    // Full rotation
    cycle(1'b0, 1'b1, 8'hFF);
    chk("rot_first_valid", int'(val0), 1);
    chk("rot_first_sel", int'(sel0), 0);
    for (int k = 0; k < 31; k++) cycle(1'b0, 1'b1, 8'hFF);
    chk("rot_cnt32", int'(cnt0), 8);
    chk("rot_pulses", pulses, 8);
    chk("rot_valid_still", int'(val0), 1);
    cycle(1'b0, 1'b1, 8'hFF);
    chk("rot_nstarts", starts.size(), 9);
    for (int k = 0; k < 9 && k < starts.size(); k++) chk("rot_order", starts[k], k % 8);

    // Sparse requests
    do_reset();
    for (int k = 0; k < 16; k++) cycle(1'b0, 1'b1, 8'b1010_0100);
    chk("sparse_n", starts.size(), 4);
    if (starts.size() == 4) begin
      chk("sparse_0", starts[0], 2);
      chk("sparse_1", starts[1], 5);
      chk("sparse_2", starts[2], 7);
      chk("sparse_3", starts[3], 2);
    end

    // Lone requester, then drop it mid-dwell
    do_reset();
    for (int k = 0; k < 13; k++) cycle(1'b0, 1'b1, 8'h08);
    chk("lone_cnt", int'(cnt0), 4);
    chk("lone_n", starts.size(), 4);
    cycle(1'b0, 1'b1, 8'h00);
    chk("lone_hold", int'(val0), 1);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 8'h00);
    chk("lone_idle_valid", int'(val0), 0);
    chk("lone_idle_grant", int'(gnt0), 0);
    chk("lone_idle_sel", int'(sel0), 3);
    chk("lone_idle_cnt", int'(cnt0), 4);

    // Enable gating during the second grant
    do_reset();
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 8'hFF);
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 8'hFF);
    chk("gate_valid", int'(val0), 0);
    chk("gate_cnt", int'(cnt0), 2);
    chk("gate_sel", int'(sel0), 1);
    cycle(1'b0, 1'b1, 8'hFF);
    chk("gate_resume_sel", int'(sel0), 2);
    chk("gate_resume_cnt", int'(cnt0), 3);

    // Reset on the second cycle of a dwell on channel 5
    do_reset();
    cycle(1'b0, 1'b1, 8'h20);
    cycle(1'b0, 1'b1, 8'h20);
    chk("mid_sel5", int'(sel0), 5);
    cycle(1'b1, 1'b1, 8'h30);
    chk("mid_valid", int'(val0), 0);
    chk("mid_sel", int'(sel0), 0);
    chk("mid_cnt", int'(cnt0), 0);
    cycle(1'b0, 1'b1, 8'h30);
    chk("mid_first", int'(sel0), 4);

    // Randomised traffic
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      logic       r_rst;
      logic       r_en;
      logic [7:0] r_req;
      r_rst = ($urandom_range(0, 99) == 0);
      r_en  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: r_req = 8'd0;
        1: r_req = 8'(1 << $urandom_range(0, 7));
        2: r_req = 8'($urandom) & 8'($urandom);
        default: r_req = 8'($urandom);
      endcase
      cycle(r_rst, r_en, r_req);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_mux_sel_sequencer.md
Name: rr_mux_sel_sequencer

Overview:
- Upstream control stage for the 8:1 4-bit mux (Mux8x1_4x1). It drives that mux's 3-bit `sel` input.
- Eight channels raise request lines. The block grants them in round-robin order.
- Each granted channel's select code is held stable for a programmable dwell time. A valid strobe tells the downstream consumer when the mux output `y` is meaningful.
- A free-running grant counter supports debug and bench checking.

Parameters:
- DWELL, 4, number of clock cycles each selection is held. Legal range 1..255.

Ports:
- clk, input, 1, system clock. All logic is rising-edge.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, scan enable. Sampled only at grant decision points.
- req, input, 8, per-channel request. Bit i requests mux input i (bit 0 = a ... bit 7 = h).
- sel, output, 3, select code to the mux. Binary index of the granted channel.
- grant, output, 8, one-hot image of sel while valid. All zeros otherwise.
- valid, output, 1, high while a grant is being held.
- last_slot, output, 1, high on the final cycle of each dwell period.
- grant_cnt, output, 8, number of grants issued since reset. Wraps 255->0.

Behaviour:
- Reset (rst=1 at a clk edge, takes priority over everything):
  - sel=0, grant=0, valid=0, last_slot=0, grant_cnt=0.
  - State is IDLE, dwell counter is 0.
  - Internal last-granted pointer is 7, so the first search begins at channel 0.
  - Reset asserted mid-dwell aborts the dwell immediately; outputs take reset values on the next edge.
- States:
  - IDLE: no active grant.
  - HOLD: a grant is active and the dwell counter is running.
- Arbitration function:
  - Search order is ptr+1, ptr+2, ..., ptr+8, all mod 8.
  - The first index with req set wins. ptr itself is searched last, so a lone requester can be re-granted.
- IDLE behaviour:
  - If en=1 and req!=0 at an edge: move to HOLD. In the same edge set sel=winner, grant=onehot(winner), valid=1, ptr=winner, counter=DWELL-1, and grant_cnt+1.
  - Latency from request to grant is exactly 1 cycle.
  - Otherwise stay in IDLE. sel keeps its previous value; valid=0, grant=0.
- HOLD behaviour:
  - While counter != 0, decrement it each cycle. sel, grant and valid stay constant.
  - req and en changes are ignored during a dwell. A request dropped mid-dwell does not shorten the dwell.
  - last_slot = valid AND (counter==0). It is combinational from state.
  - At the edge ending a cycle with counter==0:
    - If en=1 and req!=0: re-arbitrate with no bubble. New sel/grant load on that edge and valid stays 1.
    - Otherwise go to IDLE with valid=0 and grant=0; sel holds its last value.
- DWELL=1: every HOLD cycle is a last_slot. Back-to-back grants change sel every cycle.
- grant_cnt increments exactly once per grant, including consecutive re-grants of the same channel.
- sel never changes while valid=1 except on the edge that starts a new grant.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req=8'hFF -> sel=0, grant=0, valid=0, grant_cnt=0 throughout.
- Full rotation: DWELL=4, en=1, req=8'hFF from cycle 0:
  - valid rises 1 cycle later.
  - sel steps 0,1,2,...,7,0, each held exactly 4 cycles, with no gap between grants.
  - last_slot pulses every 4th cycle.
  - grant_cnt=8 after 32 cycles of valid.
- Sparse requests: req=8'b1010_0100 -> sel sequence 2,5,7,2. Each grant matches onehot(sel).
- Lone requester with dwell expiry:
  - req=8'h08 -> sel=3 re-granted back-to-back and grant_cnt increments every DWELL cycles.
  - Drop req mid-dwell -> dwell completes, then valid=0, grant=0, sel stays 3.
- Enable gating: deassert en during the second grant -> that dwell completes, block idles, grant_cnt frozen. Reassert en -> next grant starts from the channel after the last granted one.
- Mid-dwell reset: assert rst on cycle 2 of a dwell with sel=5 -> next edge gives valid=0, sel=0, grant_cnt=0. After release, the first grant goes to the lowest requesting channel.
